apb_reg_slave: RTL and testbench

- APB completer (slave) that sits directly downstream of the team's APB master and answers its transfers.
- Holds a small bank of 32-bit registers inside an address window and inserts a programmable number of wait states.
- Flags out-of-window and read-only violations on pslverr_o.
- The window by default covers 0xDEAD_CAE0-0xDEAD_CAFF, so the master's fixed address 0xDEAD_CAFE maps to register 7.

---
 rtl/apb_reg_slave.sv | 70 +++++++
 tb/tb_apb_reg_slave.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/apb_reg_slave.sv
// apb_reg_slave: APB completer with a 32-bit register bank, programmable wait states and error flagging.
// Define APB_SLV_XFER_CNT_EN to turn register 1 into a read-only count of completed transfers.
module apb_reg_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'hDEAD_CAE0,
    parameter int          NUM_REGS    = 8,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] ID_VALUE    = 32'hA9B0_0016
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        psel_i,
    input  logic        penable_i,
    input  logic [31:0] paddr_i,
    input  logic        pwrite_i,
    input  logic [31:0] pwdata_i,
    output logic        pready_o,
    output logic [31:0] prdata_o,
    output logic        pslverr_o,
    output logic        wr_pulse_o
);
    localparam int IW = $clog2(NUM_REGS);
    localparam logic [31:0] MASK = ~(32'(4 * NUM_REGS) - 32'd1);

    typedef enum logic {ST_IDLE, ST_ACCESS} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] regs [NUM_REGS];
    logic        hit, ro, wr_ok;
    logic [IW-1:0] idx;

    assign hit = (paddr_i & MASK) == BASE_ADDR;
    assign idx = paddr_i[IW+1:2];
`ifdef APB_SLV_XFER_CNT_EN
    assign ro = idx == IW'(0) || idx == IW'(1);
`else
    assign ro = idx == IW'(0);
`endif
    assign pready_o  = state == ST_ACCESS && psel_i && penable_i && cnt == 4'd0;
    assign pslverr_o = pready_o && (!hit || (pwrite_i && ro));
    assign prdata_o  = (pready_o && !pwrite_i && !pslverr_o) ? regs[idx] : 32'd0;
    assign wr_ok     = pready_o && pwrite_i && !pslverr_o;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            cnt        <= 4'd0;
            wr_pulse_o <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= (i == 0) ? ID_VALUE : 32'd0;
        end else begin
            wr_pulse_o <= wr_ok;
            if (wr_ok) regs[idx] <= pwdata_i;
`ifdef APB_SLV_XFER_CNT_EN
            if (pready_o && !pslverr_o) regs[1] <= regs[1] + 32'd1;
`endif
            // wait counter holds at zero; completion only happens from zero
            case (state)
                ST_IDLE: if (psel_i && !penable_i) begin
                    state <= ST_ACCESS;
                    cnt   <= 4'(WAIT_CYCLES);
                end
                ST_ACCESS: if (!psel_i) state <= ST_IDLE;
                    else if (penable_i) begin
                        if (cnt != 4'd0) cnt <= cnt - 4'd1;
                        else state <= ST_IDLE;
                    end
            endcase
        end
    end
endmodule

// File: tb/tb_apb_reg_slave.sv
// tb_apb_reg_slave: randomized APB transfers checked by a scoreboard against a register-bank model.
module tb_apb_reg_slave;
    localparam logic [31:0] BASE = 32'hDEAD_CAE0;
    localparam int          NR   = 8;
    localparam int          W    = 2;
    localparam logic [31:0] ID   = 32'hA9B0_0016;
`ifdef APB_SLV_XFER_CNT_EN
    localparam bit CNT = 1'b1;
`else
    localparam bit CNT = 1'b0;
`endif

    typedef struct {
        logic        err;
        logic [31:0] rd;
        logic        wp;
    } exp_t;

    logic        clk = 1'b0, reset = 1'b0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] paddr = '0, pwdata = '0;
    logic        pready_o, pslverr_o, wr_pulse_o;
    logic [31:0] prdata_o;

    int          total = 0, bad = 0;
    exp_t        q[$];
    logic [31:0] model [NR];
    logic        wp_exp = 1'b0;

    apb_reg_slave #(.BASE_ADDR(BASE), .NUM_REGS(NR), .WAIT_CYCLES(W), .ID_VALUE(ID)) dut (
        .clk(clk), .reset(reset), .psel_i(psel), .penable_i(penable), .paddr_i(paddr),
        .pwrite_i(pwrite), .pwdata_i(pwdata), .pready_o(pready_o), .prdata_o(prdata_o),
        .pslverr_o(pslverr_o), .wr_pulse_o(wr_pulse_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) model[i] = (i == 0) ? ID : 32'd0;
    endtask

    // Expected response computed from window arithmetic, pushed at issue time
    task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d);
        exp_t e;
        int   n, ix;
        logic h;
        h  = longint'(a) >= longint'(BASE) && longint'(a) < longint'(BASE) + 4 * NR;
        ix = h ? int'((a - BASE) / 4) : 0;
        e.err = !h || (w && (ix == 0 || (CNT && ix == 1)));
        e.rd  = (!w && !e.err) ? model[ix] : 32'd0;
        e.wp  = w && !e.err;
        if (e.wp) model[ix] = d;
        if (CNT && !e.err) model[1] = model[1] + 32'd1;
        q.push_back(e);
        psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = d;
        @(posedge clk); #1 penable = 1'b1;
        n = 0;
        do begin
            n++;
            @(negedge clk);
        end while (!pready_o && n < 20);
        chk("latency", n, W + 1);
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            chk("rst_pready", {31'd0, pready_o}, 0);
            chk("rst_pslverr", {31'd0, pslverr_o}, 0);
            chk("rst_prdata", prdata_o, 0);
            chk("rst_wr_pulse", {31'd0, wr_pulse_o}, 0);
            wp_exp = 1'b0;
        end else begin
            chk("wr_pulse", {31'd0, wr_pulse_o}, {31'd0, wp_exp});
            wp_exp = 1'b0;
            if (pready_o) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_pready: got 1 expected 0 at %0t", $time);
                end else begin
                    e = q.pop_front();
                    chk("pslverr", {31'd0, pslverr_o}, {31'd0, e.err});
                    chk("prdata", prdata_o, e.rd);
                    wp_exp = e.wp;
                end
            end else begin
                chk("idle_prdata", prdata_o, 0);
                chk("idle_pslverr", {31'd0, pslverr_o}, 0);
            end
        end
    end

    initial begin
        logic [31:0] a;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        xfer(BASE, 1'b0, 0);
        for (int i = 1; i <= 5; i++) begin
            xfer(32'hDEAD_CAFE, 1'b0, 0);
            xfer(32'hDEAD_CAFE, 1'b1, 32'(i));
            xfer(32'hDEAD_CAFE, 1'b0, 0);
        end
        xfer(32'hDEAD_0000, 1'b1, 32'h1234);
        xfer(32'hDEAD_0000, 1'b0, 0);
        xfer(BASE, 1'b1, 32'hFFFF_FFFF);
        xfer(BASE, 1'b0, 0);
        xfer(BASE - 4, 1'b0, 0);
        xfer(BASE + 4 * NR, 1'b1, 32'h77);
        xfer(BASE + 4, 1'b1, 32'h0BAD_F00D);
        xfer(BASE + 4, 1'b0, 0);
        // abort: psel drops in the second access cycle of a write
        psel = 1'b1; penable = 1'b0; paddr = 32'hDEAD_CAFE; pwrite = 1'b1; pwdata = 32'hBEEF;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        xfer(32'hDEAD_CAFE, 1'b0, 0);
        for (int i = 0; i < 80; i++) begin
            a = ($urandom_range(0, 4) == 0) ? $urandom() : BASE + 32'($urandom_range(0, 4 * NR - 1));
            xfer(a, 1'($urandom_range(0, 1)), $urandom());
        end
        // reset asserted in the completing access cycle of a write
        psel = 1'b1; penable = 1'b0; paddr = BASE + 12; pwrite = 1'b1; pwdata = 32'h5A5A;
        @(posedge clk); #1 penable = 1'b1;
        repeat (W) @(posedge clk);
        #1 chk("pre_reset_pready", {31'd0, pready_o}, 1);
        reset = 1'b0;
        #1 chk("reset_pready", {31'd0, pready_o}, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1; psel = 1'b0; penable = 1'b0;
        for (int i = 0; i < NR; i++) xfer(BASE + 32'(4 * i), 1'b0, 0);
        repeat (4) @(posedge clk);
        chk("queue_empty", 32'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
